// File: rtl/ocp_pkg.sv
// OCP encodings shared by the burst memory bridge and its bench.
package ocp_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE = 3'd0,
        CMD_WR   = 3'd1,
        CMD_RD   = 3'd2
    } ocp_cmd_e;

    typedef enum logic [1:0] {
        RESP_NULL = 2'd0,
        RESP_DVA  = 2'd1,
        RESP_ERR  = 2'd3
    } ocp_resp_e;

endpackage

// File: rtl/ocp_mem_watchdog.sv
// Counts cycles a memory request stays outstanding and pulses timeout on the
// cycle the count reaches TIMEOUT_CYCLES, unless completion arrives then.
module ocp_mem_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic active,
    input  logic complete,
    output logic timeout
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_cur;

    // cnt_cur includes the current cycle, so the request is held exactly LIMIT cycles
    always_comb begin
        cnt_cur = start ? CW'(1) : cnt_q + CW'(1);
        timeout = active && !complete && (cnt_cur == LIMIT);
        cnt_d   = (active && !complete && !timeout) ? cnt_cur : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ocp_burst_mem_bridge.sv
// OCP slave to single-port memory bridge: write bursts (one command per beat),
// read bursts (one command, many responses), byte enables and a request watchdog.
module ocp_burst_mem_bridge
    import ocp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 5,
    parameter int unsigned BURST_LEN_WIDTH = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 ocp_mcmd,
    input  logic [ADDR_WIDTH-1:0]      ocp_maddr,
    input  logic [DATA_WIDTH-1:0]      ocp_mdata,
    input  logic [DATA_WIDTH/8-1:0]    ocp_mbyteen,
    input  logic [BURST_LEN_WIDTH-1:0] ocp_mburstlength,
    output logic                       ocp_scmdaccept,
    output logic [1:0]                 ocp_sresp,
    output logic [DATA_WIDTH-1:0]      ocp_sdata,
    input  logic                       ocp_mrespaccept,
    output logic                       mem_access_request,
    output logic                       mem_access_type,
    output logic [ADDR_WIDTH-1:0]      mem_address,
    output logic [DATA_WIDTH-1:0]      mem_write_data,
    output logic [DATA_WIDTH/8-1:0]    mem_byte_enable,
    input  logic [DATA_WIDTH-1:0]      mem_read_data,
    input  logic                       mem_access_complete,
    output logic                       busy
);

    localparam int unsigned BE_W = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM_WR,
        ST_WR_NEXT,
        ST_WR_RESP,
        ST_MEM_RD,
        ST_RD_RESP,
        ST_ERR_RESP
    } state_e;

    state_e                     state_q;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [DATA_WIDTH-1:0]      data_q;
    logic [BE_W-1:0]            be_q;
    logic [BURST_LEN_WIDTH-1:0] len_q;
    logic [BURST_LEN_WIDTH-1:0] beat_q;
    logic                       err_q;
    logic                       req_q;
    logic                       start_q;
    logic                       wr_q;
    ocp_resp_e                  sresp_q;
    logic [DATA_WIDTH-1:0]      sdata_q;
    logic                       wd_timeout;

    ocp_mem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .start   (start_q),
        .active  (req_q),
        .complete(mem_access_complete),
        .timeout (wd_timeout)
    );

    assign ocp_scmdaccept     = ((state_q == ST_IDLE) || (state_q == ST_WR_NEXT)) &&
                                (ocp_mcmd != CMD_IDLE);
    assign ocp_sresp          = sresp_q;
    assign ocp_sdata          = sdata_q;
    assign mem_access_request = req_q;
    assign mem_access_type    = wr_q;
    assign mem_address        = addr_q;
    assign mem_write_data     = data_q;
    assign mem_byte_enable    = be_q;
    assign busy               = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            start_q <= 1'b0;
            wr_q    <= 1'b0;
            sresp_q <= RESP_NULL;
            sdata_q <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ocp_mcmd != CMD_IDLE) begin
                        if (ocp_mcmd == CMD_WR && ocp_mburstlength != '0) begin
                            addr_q  <= ocp_maddr;
                            data_q  <= ocp_mdata;
                            be_q    <= ocp_mbyteen;
                            len_q   <= ocp_mburstlength;
                            beat_q  <= BURST_LEN_WIDTH'(1);
                            wr_q    <= 1'b1;
                            req_q   <= |ocp_mbyteen;
                            start_q <= |ocp_mbyteen;
                            state_q <= ST_MEM_WR;
                        end else if (ocp_mcmd == CMD_RD && ocp_mburstlength != '0) begin
                            addr_q  <= ocp_maddr;
                            be_q    <= '1;
                            len_q   <= ocp_mburstlength;
                            beat_q  <= BURST_LEN_WIDTH'(1);
                            wr_q    <= 1'b0;
                            req_q   <= 1'b1;
                            start_q <= 1'b1;
                            state_q <= ST_MEM_RD;
                        end else begin
                            sresp_q <= RESP_ERR;
                            state_q <= ST_ERR_RESP;
                        end
                    end
                end

                // a beat with no request in flight (zero BE or prior error) completes at once
                ST_MEM_WR: begin
                    if (!req_q || mem_access_complete || wd_timeout) begin
                        req_q <= 1'b0;
                        if (wd_timeout) begin
                            err_q <= 1'b1;
                        end
                        if (beat_q == len_q) begin
                            sresp_q <= (err_q || wd_timeout) ? RESP_ERR : RESP_DVA;
                            state_q <= ST_WR_RESP;
                        end else begin
                            state_q <= ST_WR_NEXT;
                        end
                    end
                end

                ST_WR_NEXT: begin
                    if (ocp_mcmd == CMD_WR) begin
                        addr_q  <= addr_q + ADDR_WIDTH'(1);
                        beat_q  <= beat_q + BURST_LEN_WIDTH'(1);
                        data_q  <= ocp_mdata;
                        be_q    <= ocp_mbyteen;
                        req_q   <= (|ocp_mbyteen) && !err_q;
                        start_q <= (|ocp_mbyteen) && !err_q;
                        state_q <= ST_MEM_WR;
                    end else if (ocp_mcmd != CMD_IDLE) begin
                        err_q   <= 1'b1;
                        sresp_q <= RESP_ERR;
                        state_q <= ST_ERR_RESP;
                    end
                end

                ST_WR_RESP, ST_ERR_RESP: begin
                    if (ocp_mrespaccept) begin
                        sresp_q <= RESP_NULL;
                        err_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                ST_MEM_RD: begin
                    if (!req_q) begin
                        sresp_q <= RESP_ERR;
                        sdata_q <= '0;
                        state_q <= ST_RD_RESP;
                    end else if (mem_access_complete) begin
                        req_q   <= 1'b0;
                        sdata_q <= mem_read_data;
                        sresp_q <= RESP_DVA;
                        state_q <= ST_RD_RESP;
                    end else if (wd_timeout) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        sdata_q <= '0;
                        sresp_q <= RESP_ERR;
                        state_q <= ST_RD_RESP;
                    end
                end

                ST_RD_RESP: begin
                    if (ocp_mrespaccept) begin
                        sresp_q <= RESP_NULL;
                        if (beat_q < len_q) begin
                            addr_q  <= addr_q + ADDR_WIDTH'(1);
                            beat_q  <= beat_q + BURST_LEN_WIDTH'(1);
                            req_q   <= !err_q;
                            start_q <= !err_q;
                            state_q <= ST_MEM_RD;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ocp_burst_mem_bridge.md
Name: ocp_burst_mem_bridge

Overview:
- OCP slave to single-port memory master bridge with burst support, byte enables, response backpressure and a memory-timeout watchdog.
- Sits between an OCP master (CPU/DMA port) and a word-addressed memory controller.
- Converts OCP write bursts (one command per beat) and read bursts (single request, multiple data) into sequential memory accesses.
- Returns DVA or ERR responses to the OCP master.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8.
- ADDR_WIDTH, 5, word address width.
- BURST_LEN_WIDTH, 4, width of the burst-length field; legal lengths are 1..2^BURST_LEN_WIDTH-1.
- TIMEOUT_CYCLES, 255, maximum number of cycles a memory request may stay outstanding before it is aborted.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ocp_mcmd  in  3  OCP command: IDLE=0, WR=1, RD=2; other encodings are illegal
- ocp_maddr  in  ADDR_WIDTH  burst start word address
- ocp_mdata  in  DATA_WIDTH  write data
- ocp_mbyteen  in  DATA_WIDTH/8  write byte enables
- ocp_mburstlength  in  BURST_LEN_WIDTH  number of beats in the burst
- ocp_scmdaccept  out  1  command accepted this cycle
- ocp_sresp  out  2  response: NULL=0, DVA=1, ERR=3
- ocp_sdata  out  DATA_WIDTH  read response data
- ocp_mrespaccept  in  1  master accepts the current response
- mem_access_request  out  1  memory request; held until complete or timeout
- mem_access_type  out  1  1=write, 0=read
- mem_address  out  ADDR_WIDTH  memory word address
- mem_write_data  out  DATA_WIDTH  memory write data
- mem_byte_enable  out  DATA_WIDTH/8  memory byte enables; all ones for reads
- mem_read_data  in  DATA_WIDTH  memory read data
- mem_access_complete  in  1  single-cycle completion pulse from memory
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset state: all outputs 0, ocp_sresp=NULL, state=IDLE; beat counter, address register and err_flag cleared. Reset mid-burst abandons the burst silently.
- States: IDLE, MEM_WR, WR_NEXT, WR_RESP, MEM_RD, RD_RESP, ERR_RESP.
- Command accept (combinational):
  - ocp_scmdaccept = 1 in IDLE when ocp_mcmd != IDLE.
  - ocp_scmdaccept = 1 in WR_NEXT when ocp_mcmd != IDLE.
  - 0 in all other states.
- IDLE, WR with length >= 1:
  - Latch address, data and byte enables; set len = ocp_mburstlength, beat = 1.
  - Go to MEM_WR. mem_access_request rises on the next cycle.
- IDLE, RD with length >= 1: latch address and len; go to MEM_RD.
- IDLE, illegal command or length 0: accept, go to ERR_RESP; no memory access.
- MEM_WR / MEM_RD:
  - Request and address/data outputs are registered and stable until mem_access_complete. mem_access_complete is ignored when no request is active.
  - Write beat with all byte enables zero: no memory request; the beat is treated as complete immediately.
  - err_flag set: no memory access; the beat is treated as complete immediately.
- On write completion:
  - beat == len: go to WR_RESP.
  - Otherwise: go to WR_NEXT.
- WR_NEXT:
  - WR accepted: address register += 1, beat += 1, latch data and byte enables, go to MEM_WR. ocp_maddr of non-first beats is ignored.
  - RD or illegal command: accepted and dropped; set err_flag, go to ERR_RESP.
- WR_RESP: ocp_sresp = DVA, or ERR if err_flag is set; hold until ocp_mrespaccept, then go to IDLE and clear err_flag.
- On read completion: capture mem_read_data into ocp_sdata, go to RD_RESP.
- RD_RESP:
  - ocp_sresp = DVA (ERR with ocp_sdata=0 if err_flag is set); hold until ocp_mrespaccept.
  - Then, if beat < len: address += 1, beat += 1, go to MEM_RD. Otherwise go to IDLE and clear err_flag.
- Address increment wraps modulo 2^ADDR_WIDTH (31 -> 0 at the default width).
- Watchdog:
  - Counts cycles with mem_access_request high; cleared on completion or on a new request.
  - When the count reaches TIMEOUT_CYCLES: drop the request and set err_flag.
    - Read: go to RD_RESP with ERR; remaining read beats each return ERR with no memory access.
    - Write: continue beat handling without memory access; the single final response is ERR.
  - Completion and timeout in the same cycle: completion wins.
- Response timing: ocp_sresp/ocp_sdata are registered. Once the response is accepted (ocp_mrespaccept high with sresp != NULL), the next cycle shows NULL.
- Minimum latency: single read with 1-cycle memory completion gives a DVA response 3 cycles after command accept.

Decomposition:
- ocp_pkg: MCmd and SResp encodings (ocp_cmd_e, ocp_resp_e).
- Bridge state enum stays local to the module.
- Sub-module ocp_mem_watchdog: parametrised by TIMEOUT_CYCLES; inputs start/active/complete; output timeout pulse.

Test Plan:
- Single write: WR addr 3, data 0xDEADBEEF, BE 0xF, len 1, memory completes after 2 cycles -> memory sees exactly one write; one DVA response; busy returns to 0.
- Read burst with backpressure: RD addr 30, len 4, ocp_mrespaccept withheld 3 cycles on beat 2 -> memory addresses 30, 31, 0, 1 in order; 4 DVA responses with matching data; request never overlaps a pending response.
- Write burst BE handling: len 3, beat 2 BE=0 -> exactly two memory writes (addr a, a+2); one DVA response after beat 3.
- Write timeout: memory never completes on beat 1 of a len-2 write -> request drops after 255 cycles; beat 2 accepted with no memory access; final response ERR.
- Illegal command: ocp_mcmd=5, or RD with length 0 -> accepted; single ERR response; no memory request.
- Reset mid read burst: reset asserted during MEM_RD -> next cycle all outputs 0 and busy=0; a following single read works normally.
